// File: rtl/a1_stepper.sv
// rtl/a1_stepper.sv - Blitter A1 pointer stepping stage (A1_SAT_EN: signed saturating step add)
// Holds A1 pointer/step/count; stepped pointers loop back through the external data mux.
module a1_stepper #(
  parameter int PTR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PTR_W-1:0] data_x,
  input  logic [PTR_W-1:0] data_y,
  input  logic             ld_x,
  input  logic             ld_y,
  input  logic             ld_inc,
  input  logic             ld_cnt,
  input  logic             go,
  input  logic             stall,
  output logic [PTR_W-1:0] addq_x,
  output logic [PTR_W-1:0] addq_y,
  output logic             addqsel,
  output logic [PTR_W-1:0] a1_x,
  output logic [PTR_W-1:0] a1_y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, STEP, WB, DONE} state_t;

  state_t           state, state_next;
  logic [PTR_W-1:0] inc_x, inc_y, count;

  function automatic logic [PTR_W-1:0] add_step(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
    logic [PTR_W-1:0] s;
    s = a + b;
`ifdef A1_SAT_EN
    // Overflow only when both operands share a sign that the sum does not.
    if ((a[PTR_W-1] == b[PTR_W-1]) && (s[PTR_W-1] != a[PTR_W-1]))
      s = a[PTR_W-1] ? {1'b1, {(PTR_W-1){1'b0}}} : {1'b0, {(PTR_W-1){1'b1}}};
`endif
    return s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!stall) begin
      case (state)
        IDLE: if (go) state_next = (count == '0) ? DONE : STEP;
        STEP: state_next = WB;
        WB:   state_next = (count == PTR_W'(1)) ? DONE : STEP;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_x    <= '0;
      a1_y    <= '0;
      addq_x  <= '0;
      addq_y  <= '0;
      inc_x   <= '0;
      inc_y   <= '0;
      count   <= '0;
      addqsel <= 1'b0;
    end else if (!stall) begin
      // Registered select so the mux sees a glitch-free control during WB.
      addqsel <= (state_next == WB);
      case (state)
        IDLE: begin
          if (ld_x)   a1_x  <= data_x;
          if (ld_y)   a1_y  <= data_y;
          if (ld_inc) begin
            inc_x <= data_x;
            inc_y <= data_y;
          end
          if (ld_cnt) count <= data_x;
        end
        STEP: begin
          addq_x <= add_step(a1_x, inc_x);
          addq_y <= add_step(a1_y, inc_y);
        end
        WB: begin
          a1_x  <= data_x;
          a1_y  <= data_y;
          count <= count - PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == STEP) || (state == WB);
  assign done = (state == DONE);

endmodule

// File: tb/tb_a1_stepper.sv
// tb/tb_a1_stepper.sv - directed self-checking bench for a1_stepper
// Models the external address data mux so write-back loops through data_x/data_y.
module tb_a1_stepper;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] gpu_x, gpu_y;
  logic [15:0] data_x, data_y;
  logic        ld_x, ld_y, ld_inc, ld_cnt, go, stall;
  logic [15:0] addq_x, addq_y, a1_x, a1_y;
  logic        addqsel, busy, done;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign data_x = addqsel ? addq_x : gpu_x;
  assign data_y = addqsel ? addq_y : gpu_y;

  a1_stepper #(.PTR_W(16)) dut (
    .clk(clk), .reset(reset), .data_x(data_x), .data_y(data_y),
    .ld_x(ld_x), .ld_y(ld_y), .ld_inc(ld_inc), .ld_cnt(ld_cnt),
    .go(go), .stall(stall), .addq_x(addq_x), .addq_y(addq_y),
    .addqsel(addqsel), .a1_x(a1_x), .a1_y(a1_y), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_x = 0; ld_y = 0; ld_inc = 0; ld_cnt = 0; go = 0;
  endtask

  logic [15:0] sat_exp;

  initial begin
    reset = 1; stall = 0; gpu_x = 0; gpu_y = 0;
    idle_inputs();
    tick(); tick();
    check("rst_a1_x", a1_x, 16'h0000);
    check("rst_a1_y", a1_y, 16'h0000);
    check("rst_addq_x", addq_x, 16'h0000);
    check("rst_addq_y", addq_y, 16'h0000);
    check("rst_flags", {13'd0, addqsel, busy, done}, 16'h0000);
    reset = 0;
    tick();

    // Three steps, with an ignored ld_x while busy
    gpu_x = 16'h0010; gpu_y = 16'h0020; ld_x = 1; ld_y = 1;
    tick();
    check("load_a1_x", a1_x, 16'h0010);
    check("load_a1_y", a1_y, 16'h0020);
    idle_inputs(); gpu_x = 16'h0001; gpu_y = 16'hFFFF; ld_inc = 1;
    tick();
    idle_inputs(); gpu_x = 16'h0003; ld_cnt = 1;
    tick();
    idle_inputs(); go = 1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      idle_inputs();
      if (c == 3) begin ld_x = 1; gpu_x = 16'h1234; end
      check($sformatf("t1_addqsel_c%0d", c), {15'd0, addqsel}, {15'd0, (c == 2 || c == 4 || c == 6)});
      check($sformatf("t1_done_c%0d", c), {15'd0, done}, {15'd0, (c == 7)});
      check($sformatf("t1_busy_c%0d", c), {15'd0, busy}, {15'd0, (c >= 1 && c <= 6)});
      if (c == 2) check("t1_addq_x_c2", addq_x, 16'h0011);
      if (c == 2) check("t1_addq_y_c2", addq_y, 16'h001F);
      if (c == 3) check("t1_a1_x_c3", a1_x, 16'h0011);
    end
    check("t1_final_x", a1_x, 16'h0013);
    check("t1_final_y", a1_y, 16'h001D);

    // Overflow at 0x7FFF: simultaneous ld_inc and ld_cnt from data_x = 1
`ifdef A1_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h8000;
`endif
    gpu_x = 16'h7FFF; ld_x = 1;
    tick();
    idle_inputs(); gpu_x = 16'h0001; gpu_y = 16'h0000; ld_inc = 1; ld_cnt = 1;
    tick();
    idle_inputs(); go = 1;
    tick(); idle_inputs();
    tick(); tick();
    check("t2_done", {15'd0, done}, 16'h0001);
    check("t2_ovf_x", a1_x, sat_exp);
    check("t2_y_keep", a1_y, 16'h001D);
    tick();

    // 0xFFFF + 1 wraps to zero in both builds
    gpu_x = 16'hFFFF; ld_x = 1; ld_cnt = 0;
    tick();
    idle_inputs(); gpu_x = 16'h0001; ld_cnt = 1;
    tick();
    idle_inputs(); go = 1;
    tick(); idle_inputs();
    tick(); tick();
    check("t2_wrap_x", a1_x, 16'h0000);
    tick();

    // Count zero: done in cycle 1, no write-back
    gpu_x = 16'h0000; ld_cnt = 1;
    tick();
    idle_inputs(); go = 1;
    tick(); idle_inputs();
    check("t3_done_c1", {15'd0, done}, 16'h0001);
    check("t3_addqsel", {15'd0, addqsel}, 16'h0000);
    check("t3_busy", {15'd0, busy}, 16'h0000);
    tick();
    check("t3_done_c2", {15'd0, done}, 16'h0000);
    check("t3_x", a1_x, 16'h0000);
    check("t3_y", a1_y, 16'h001D);

    // Stall for 3 cycles during first WB of a two-step run
    gpu_x = 16'h0100; gpu_y = 16'h0200; ld_x = 1; ld_y = 1;
    tick();
    idle_inputs(); gpu_x = 16'h0002; gpu_y = 16'h0003; ld_inc = 1; ld_cnt = 1;
    tick();
    idle_inputs(); go = 1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      idle_inputs();
      stall = (c >= 2 && c <= 4);
      check($sformatf("t4_addqsel_c%0d", c), {15'd0, addqsel}, {15'd0, (c >= 2 && c <= 5) || c == 7});
      check($sformatf("t4_done_c%0d", c), {15'd0, done}, {15'd0, (c == 8)});
      if (c == 4) check("t4_hold_x", a1_x, 16'h0100);
    end
    stall = 0;
    check("t4_final_x", a1_x, 16'h0104);
    check("t4_final_y", a1_y, 16'h0206);

    // Reset in the cycle after the first WB of a four-step run
    gpu_x = 16'h0004; ld_cnt = 1;
    tick();
    idle_inputs(); go = 1;
    tick(); idle_inputs();
    tick();
    check("t5_wb_c2", {15'd0, addqsel}, 16'h0001);
    tick();
    reset = 1;
    #1;
    check("t5_rst_x", a1_x, 16'h0000);
    check("t5_rst_y", a1_y, 16'h0000);
    check("t5_rst_addq", addq_x | addq_y, 16'h0000);
    check("t5_rst_flags", {13'd0, addqsel, busy, done}, 16'h0000);
    tick();
    reset = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("t5_nodone_%0d", c), {15'd0, done | busy}, 16'h0000);
    end
    go = 1;
    tick(); idle_inputs();
    check("t5_cnt0_done", {15'd0, done}, 16'h0001);
    tick();
    check("t5_idle", {14'd0, busy, done}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
